// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, a sliding window and one
// registered result per interior pixel, in one of four runtime-selectable modes.
module sobel_stream #(
   parameter int unsigned PIX_W = 8,
   parameter int unsigned IMG_W = 640,
   parameter int unsigned IMG_H = 480
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   input  logic [1:0]       mode,
   input  logic [PIX_W+2:0] thresh,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_pixel,
   output logic             out_last
);
   localparam int unsigned W  = PIX_W + 3;
   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam logic [W-1:0] MAX = {3'b000, {PIX_W{1'b1}}};

   logic [CW-1:0]    col;
   logic [RW-1:0]    row;
   logic [1:0]       mode_q;
   logic [W-1:0]     thresh_q;
   logic [PIX_W-1:0] lb1 [IMG_W];
   logic [PIX_W-1:0] lb2 [IMG_W];
   logic [PIX_W-1:0] win [3][2];
   logic [PIX_W-1:0] p [3][3];
   logic             accept, produce, col_end, row_end, last_px;
   logic signed [W-1:0] gx, gy;
   logic [W-1:0]     agx, agy, mag;
   logic [PIX_W-1:0] result;

   function automatic logic [W-1:0] ext(input logic [PIX_W-1:0] v);
      return {3'b000, v};
   endfunction

   function automatic logic [W-1:0] absv(input logic signed [W-1:0] v);
      return v[W-1] ? $unsigned(-v) : $unsigned(v);
   endfunction

   function automatic logic [PIX_W-1:0] sat(input logic [W-1:0] v);
      return (v > MAX) ? MAX[PIX_W-1:0] : v[PIX_W-1:0];
   endfunction

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign col_end  = (col == CW'(IMG_W - 1));
   assign row_end  = (row == RW'(IMG_H - 1));
   assign last_px  = row_end && col_end;
   assign produce  = accept && (row >= RW'(2)) && (col >= CW'(2));

   // Window as it will look once the incoming column has been shifted in.
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         p[i][0] = win[i][0];
         p[i][1] = win[i][1];
      end
      p[0][2] = lb2[col];
      p[1][2] = lb1[col];
      p[2][2] = in_pixel;
   end

   assign gx = $signed((ext(p[0][2]) + (ext(p[1][2]) << 1) + ext(p[2][2]))
                     - (ext(p[0][0]) + (ext(p[1][0]) << 1) + ext(p[2][0])));
   assign gy = $signed((ext(p[0][0]) + (ext(p[0][1]) << 1) + ext(p[0][2]))
                     - (ext(p[2][0]) + (ext(p[2][1]) << 1) + ext(p[2][2])));
   assign agx = absv(gx);
   assign agy = absv(gy);
   assign mag = agx + agy;

   always_comb begin
      result = '0;
      case (mode_q)
         2'd0:    result = sat(mag);
         2'd1:    result = sat(agx);
         2'd2:    result = sat(agy);
         default: result = (mag >= thresh_q) ? '1 : '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col      <= '0;
         row      <= '0;
         mode_q   <= '0;
         thresh_q <= '0;
      end else if (accept) begin
         if (col == '0 && row == '0) begin
            mode_q   <= mode;
            thresh_q <= thresh;
         end
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // Buffers and window are never cleared; row/col gating hides stale contents.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         lb2[col] <= lb1[col];
         lb1[col] <= in_pixel;
         for (int i = 0; i < 3; i++) begin
            win[i][0] <= p[i][1];
            win[i][1] <= p[i][2];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_last  <= 1'b0;
      end else if (produce) begin
         out_valid <= 1'b1;
         out_pixel <= result;
         out_last  <= last_px;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
